ir_frame_ctrl: RTL and testbench

IR_FRAME_CTRL -- requirements
Module: ir_frame_ctrl

---
 rtl/ir_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ir_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_frame_ctrl.sv
// NEC IR frame controller: measures mark/space widths in tick units, steers an
// external 33-bit shift register, validates the frame and hands out addr/cmd.
module ir_frame_ctrl #(
    parameter int LEAD_MARK_MIN  = 14,
    parameter int LEAD_SPACE_MIN = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        ir_in,
    output logic        sr_shift,
    output logic        sr_serial,
    output logic        sr_en,
    output logic        sr_reset,
    input  logic [32:0] sr_q,
    input  logic        sr_avail,
    output logic [7:0]  addr,
    output logic [7:0]  cmd,
    output logic        valid,
    input  logic        ack,
    output logic        rpt,
    output logic        err
);
    localparam logic [4:0] LM_MIN = 5'(LEAD_MARK_MIN);
    localparam logic [4:0] LS_MIN = 5'(LEAD_SPACE_MIN);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CHECK, OUT
    } state_t;

    state_t      state, next;
    logic        s1, s2, s3;
    logic        fall, rise, sat, busy;
    logic [4:0]  cnt;
    logic [5:0]  bits;
    logic        pend;
    logic        do_shift, shift_bit, latch;
    logic [7:0]  addr_rx, addr_n_rx, cmd_rx, cmd_n_rx;
    logic        unused_addr_n;

    assign fall = s3 & ~s2;
    assign rise = ~s3 & s2;
    assign sat  = (cnt == 5'd31);
    // The last data bit is still in the shift pipeline when CHECK is entered.
    assign busy = pend | sr_shift;

    always_comb begin
        addr_rx   = '0;
        addr_n_rx = '0;
        cmd_rx    = '0;
        cmd_n_rx  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            addr_rx[i]   = sr_q[31 - i];
            addr_n_rx[i] = sr_q[23 - i];
            cmd_rx[i]    = sr_q[15 - i];
            cmd_n_rx[i]  = sr_q[7 - i];
        end
    end

    assign unused_addr_n = ^addr_n_rx;

    assign sr_en    = (state == LEAD_SPACE) || (state == BIT_MARK) ||
                      (state == BIT_SPACE)  || (state == CHECK);
    assign sr_reset = (state == IDLE);
    assign valid    = (state == OUT);

    always_comb begin
        next      = state;
        do_shift  = 1'b0;
        shift_bit = 1'b0;
        latch     = 1'b0;
        rpt       = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: if (fall) next = LEAD_MARK;
            LEAD_MARK: begin
                if (rise) begin
                    if (cnt >= LM_MIN) next = LEAD_SPACE;
                    else begin err = 1'b1; next = IDLE; end
                end else if (sat) begin
                    err = 1'b1; next = IDLE;
                end
            end
            LEAD_SPACE: begin
                if (fall) begin
                    if (cnt >= LS_MIN) begin
                        do_shift = 1'b1; shift_bit = 1'b1; next = BIT_MARK;
                    end else if (cnt >= 5'd3 && cnt <= 5'd5) begin
                        rpt = 1'b1; next = IDLE;
                    end else begin
                        err = 1'b1; next = IDLE;
                    end
                end else if (sat) begin
                    err = 1'b1; next = IDLE;
                end
            end
            BIT_MARK: begin
                if (rise) begin
                    if (cnt >= 5'd1 && cnt <= 5'd2) next = BIT_SPACE;
                    else begin err = 1'b1; next = IDLE; end
                end else if (sat) begin
                    err = 1'b1; next = IDLE;
                end
            end
            BIT_SPACE: begin
                if (fall) begin
                    if (cnt >= 5'd1 && cnt <= 5'd4) begin
                        do_shift  = 1'b1;
                        shift_bit = (cnt >= 5'd3);
                        next      = (bits == 6'd31) ? CHECK : BIT_MARK;
                    end else begin
                        err = 1'b1; next = IDLE;
                    end
                end else if (sat) begin
                    err = 1'b1; next = IDLE;
                end
            end
            CHECK: begin
                if (!busy) begin
                    if (sr_avail && sr_q[32] && (cmd_rx == ~cmd_n_rx)) begin
                        latch = 1'b1; next = OUT;
                    end else begin
                        err = 1'b1; next = IDLE;
                    end
                end
            end
            OUT: if (ack) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            cnt       <= '0;
            bits      <= '0;
            pend      <= 1'b0;
            sr_shift  <= 1'b0;
            sr_serial <= 1'b0;
            addr      <= '0;
            cmd       <= '0;
        end else begin
            state <= next;
            s1    <= ir_in;
            s2    <= s1;
            s3    <= s2;
            if (fall || rise) cnt <= '0;
            else if (tick && !sat) cnt <= cnt + 5'd1;
            if (state == IDLE) bits <= '0;
            else if (do_shift && state == BIT_SPACE) bits <= bits + 6'd1;
            if (do_shift) sr_serial <= shift_bit;
            pend     <= do_shift;
            sr_shift <= pend;
            if (latch) begin
                addr <= addr_rx;
                cmd  <= cmd_rx;
            end
        end
    end
endmodule

// File: tb/tb_ir_frame_ctrl.sv
// Directed bench for ir_frame_ctrl with a behavioural 33-bit shift register
// attached; tick widths are driven exactly so width counts are deterministic.
module tb_ir_frame_ctrl;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        ir_in = 1'b1;
    logic        ack = 1'b0;
    logic        sr_shift, sr_serial, sr_en, sr_reset, sr_avail;
    logic [32:0] sr_q;
    logic [7:0]  addr, cmd;
    logic        valid, rpt, err;

    int checks = 0;
    int passed = 0;
    int n_err = 0, n_rpt = 0, n_both = 0, n_shift = 0, n_valid = 0, n_ser_bad = 0;
    int sr_n = 0;
    logic prev_ser = 1'b0;

    ir_frame_ctrl #(.LEAD_MARK_MIN(14), .LEAD_SPACE_MIN(6)) dut (
        .clk(clk), .reset(reset), .tick(tick), .ir_in(ir_in),
        .sr_shift(sr_shift), .sr_serial(sr_serial), .sr_en(sr_en), .sr_reset(sr_reset),
        .sr_q(sr_q), .sr_avail(sr_avail), .addr(addr), .cmd(cmd),
        .valid(valid), .ack(ack), .rpt(rpt), .err(err)
    );

    always #5 clk = ~clk;

    // External shift register: synchronous reset, shifts left on en & shift.
    assign sr_avail = (sr_n == 33);
    always @(posedge clk) begin
        if (sr_reset) begin
            sr_q <= '0;
            sr_n <= 0;
        end else if (sr_en && sr_shift) begin
            sr_q <= {sr_q[31:0], sr_serial};
            sr_n <= (sr_n == 33) ? 33 : sr_n + 1;
        end
    end

    always @(negedge clk) begin
        if (err) n_err <= n_err + 1;
        if (rpt) n_rpt <= n_rpt + 1;
        if (err && rpt) n_both <= n_both + 1;
        if (valid) n_valid <= n_valid + 1;
        if (sr_shift) begin
            n_shift <= n_shift + 1;
            if (sr_serial !== prev_ser) n_ser_bad <= n_ser_bad + 1;
        end
        prev_ser <= sr_serial;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_clks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive ir_in at lvl for n tick units; each unit ends with a one-clk tick.
    task automatic hold(input logic lvl, input int n);
        ir_in = lvl;
        for (int j = 0; j < n; j++) begin
            repeat (P - 1) begin @(posedge clk); #1; end
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] an,
                              input logic [7:0] c, input logic [7:0] cn, input int nbits);
        logic [31:0] w;
        w = {cn, c, an, a};
        hold(1'b0, 16);
        hold(1'b1, 8);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 1);
            hold(1'b1, w[i] ? 3 : 1);
        end
        if (nbits == 32) begin
            hold(1'b0, 1);
            hold(1'b1, 3);
        end
    endtask

    task automatic test_reset;
        logic [22:0] got;
        idle_clks(3);
        got = {valid, rpt, err, sr_shift, sr_serial, sr_en, sr_reset, addr, cmd};
        checks++;
        if (got !== {7'b0000001, 16'h0000})
            $display("FAIL reset_outputs: got %h expected %h", got, {7'b0000001, 16'h0000});
        else passed++;
        #3 reset = 1'b0;
        idle_clks(4);
        checks++;
        if (sr_reset !== 1'b1 || valid !== 1'b0)
            $display("FAIL idle_after_reset: sr_reset=%b valid=%b expected 1/0", sr_reset, valid);
        else passed++;
    endtask

    task automatic test_valid_frame;
        int e0, s0;
        e0 = n_err; s0 = n_shift;
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 32);
        checks++;
        if (n_shift - s0 !== 33) $display("FAIL shift_count: got %0d expected 33", n_shift - s0);
        else passed++;
        checks++;
        if (sr_q !== 33'h1_00FF_A25D) $display("FAIL sr_contents: got %h expected %h", sr_q, 33'h1_00FF_A25D);
        else passed++;
        checks++;
        if ({valid, addr, cmd} !== {1'b1, 8'h00, 8'h45})
            $display("FAIL frame_out: got %h expected %h", {valid, addr, cmd}, {1'b1, 8'h00, 8'h45});
        else passed++;
        idle_clks(20);
        checks++;
        if ({valid, addr, cmd} !== {1'b1, 8'h00, 8'h45})
            $display("FAIL frame_held: got %h expected %h", {valid, addr, cmd}, {1'b1, 8'h00, 8'h45});
        else passed++;
        ack = 1'b1;
        idle_clks(1);
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || sr_reset !== 1'b1)
            $display("FAIL ack_release: valid=%b sr_reset=%b expected 0/1", valid, sr_reset);
        else passed++;
        checks++;
        if (n_err !== e0) $display("FAIL frame_no_err: got %0d expected %0d", n_err, e0);
        else passed++;
    endtask

    task automatic test_repeat;
        int r0, s0, v0, e0;
        r0 = n_rpt; s0 = n_shift; v0 = n_valid; e0 = n_err;
        hold(1'b0, 16);
        hold(1'b1, 4);
        hold(1'b0, 1);
        hold(1'b1, 5);
        checks++;
        if (n_rpt - r0 !== 1) $display("FAIL repeat_pulse: got %0d expected 1", n_rpt - r0);
        else passed++;
        checks++;
        if ({n_shift - s0, n_valid - v0, n_err - e0} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL repeat_side: shifts=%0d valid=%0d err=%0d expected 0/0/0",
                     n_shift - s0, n_valid - v0, n_err - e0);
        else passed++;
    endtask

    task automatic test_bad_cmd;
        int e0, v0;
        e0 = n_err; v0 = n_valid;
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBB, 32);
        checks++;
        if (n_err - e0 !== 1) $display("FAIL badcmd_err: got %0d expected 1", n_err - e0);
        else passed++;
        checks++;
        if (n_valid !== v0 || valid !== 1'b0 || sr_reset !== 1'b1)
            $display("FAIL badcmd_state: valid_cycles=%0d valid=%b sr_reset=%b expected 0/0/1",
                     n_valid - v0, valid, sr_reset);
        else passed++;
    endtask

    task automatic test_timeout;
        int e0;
        e0 = n_err;
        send_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3, 10);
        hold(1'b1, 40);
        checks++;
        if (n_err - e0 !== 1) $display("FAIL timeout_err: got %0d expected 1", n_err - e0);
        else passed++;
        checks++;
        if (sr_reset !== 1'b1 || sr_en !== 1'b0)
            $display("FAIL timeout_idle: sr_reset=%b sr_en=%b expected 1/0", sr_reset, sr_en);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int e0, s0;
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 32);
        e0 = n_err; s0 = n_shift;
        send_frame(8'h12, 8'hED, 8'h9C, 8'h63, 32);
        checks++;
        if ({valid, addr, cmd} !== {1'b1, 8'h00, 8'h45})
            $display("FAIL b2b_hold: got %h expected %h", {valid, addr, cmd}, {1'b1, 8'h00, 8'h45});
        else passed++;
        checks++;
        if (n_err !== e0 || n_shift !== s0)
            $display("FAIL b2b_ignored: err=%0d shifts=%0d expected 0/0", n_err - e0, n_shift - s0);
        else passed++;
        ack = 1'b1;
        idle_clks(1);
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) $display("FAIL b2b_ack: got %b expected 0", valid);
        else passed++;
    endtask

    task automatic test_ack_same_clk;
        int v0;
        v0 = n_valid;
        ack = 1'b1;
        send_frame(8'h21, 8'hDE, 8'h07, 8'hF8, 32);
        ack = 1'b0;
        checks++;
        if (n_valid - v0 !== 1) $display("FAIL ack_early_valid_cycles: got %0d expected 1", n_valid - v0);
        else passed++;
        checks++;
        if ({addr, cmd} !== {8'h21, 8'h07})
            $display("FAIL ack_early_data: got %h expected %h", {addr, cmd}, {8'h21, 8'h07});
        else passed++;
    endtask

    task automatic test_reset_mid_frame;
        int e0, r0;
        logic [22:0] got;
        e0 = n_err; r0 = n_rpt;
        send_frame(8'h12, 8'hED, 8'h9C, 8'h63, 19);
        ir_in = 1'b0;
        @(posedge clk); @(posedge clk);
        checks++;
        if (sr_en !== 1'b1) $display("FAIL midframe_active: sr_en got %b expected 1", sr_en);
        else passed++;
        #2 reset = 1'b1;
        #1;
        got = {valid, rpt, err, sr_shift, sr_serial, sr_en, sr_reset, addr, cmd};
        checks++;
        if (got !== {7'b0000001, 16'h0000})
            $display("FAIL midframe_reset: got %h expected %h", got, {7'b0000001, 16'h0000});
        else passed++;
        ir_in = 1'b1;
        idle_clks(3);
        #3 reset = 1'b0;
        idle_clks(4);
        checks++;
        if (n_err !== e0 || n_rpt !== r0)
            $display("FAIL midframe_no_pulse: err=%0d rpt=%0d expected 0/0", n_err - e0, n_rpt - r0);
        else passed++;
        send_frame(8'h12, 8'hED, 8'h9C, 8'h63, 32);
        checks++;
        if ({valid, addr, cmd} !== {1'b1, 8'h12, 8'h9C})
            $display("FAIL post_reset_frame: got %h expected %h", {valid, addr, cmd}, {1'b1, 8'h12, 8'h9C});
        else passed++;
        ack = 1'b1;
        idle_clks(1);
        ack = 1'b0;
    endtask

    initial begin
        test_reset;
        test_valid_frame;
        test_repeat;
        test_bad_cmd;
        test_timeout;
        test_back_to_back;
        test_ack_same_clk;
        test_reset_mid_frame;
        idle_clks(2);
        checks++;
        if (n_both !== 0) $display("FAIL rpt_err_exclusive: got %0d overlaps expected 0", n_both);
        else passed++;
        checks++;
        if (n_ser_bad !== 0) $display("FAIL serial_setup: got %0d unstable shifts expected 0", n_ser_bad);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
